// File: rtl/spi_controller.sv
// spi_controller: quad-SPI register access master framing command, address, mask/dummy and data nibbles.
module spi_controller #(
  parameter int RF_AWIDTH = 8,
  parameter int RF_WIDTH  = 32,
  parameter int CLK_DIV   = 2,
  parameter int DUMMY     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [RF_AWIDTH-1:0]  req_addr,
  input  logic [RF_WIDTH-1:0]   req_wdata,
  input  logic [RF_WIDTH/8-1:0] req_wmask,
  output logic                  rsp_valid,
  output logic [RF_WIDTH-1:0]   rsp_rdata,
  output logic                  CS_N,
  output logic                  SCK,
  output logic [3:0]            COPI,
  input  logic [3:0]            CIPO
);
  localparam int AN    = RF_AWIDTH / 4;
  localparam int DN    = RF_WIDTH / 4;
  localparam int MN    = (RF_WIDTH + 31) / 32;
  localparam int MW    = MN * 4;
  localparam int WN    = 1 + AN + MN + DN;
  localparam int RN    = 1 + AN + DUMMY + DN;
  localparam int NMAX  = WN > RN ? WN : RN;
  localparam int TXW   = 4 * NMAX;
  localparam int RSKIP = 1 + AN + DUMMY;
  localparam int CW    = $clog2(CLK_DIV + 1);
  localparam int EW    = $clog2(NMAX + 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  state_t              state;
  logic                we;
  logic [TXW-1:0]      tx;
  logic [RF_WIDTH-1:0] rx;
  logic [CW-1:0]       cnt;
  logic [EW-1:0]       edges;
  logic                tick;
  logic                last;
  logic [TXW-1:0]      wload;
  logic [TXW-1:0]      rload;

  // Nibbles after the command, left-aligned; zero padding supplies dummy, read-data and trailing nibbles.
  assign wload     = {req_addr, MW'(req_wmask), req_wdata, {(TXW - 4 * (WN - 1)){1'b0}}};
  assign rload     = {req_addr, {(TXW - RF_AWIDTH){1'b0}}};
  assign tick      = cnt == CW'(CLK_DIV - 1);
  assign last      = edges == (we ? EW'(WN) : EW'(RN));
  assign req_ready = state == IDLE && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      CS_N      <= 1'b1;
      SCK       <= 1'b0;
      COPI      <= 4'h0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      we        <= 1'b0;
      tx        <= '0;
      rx        <= '0;
      cnt       <= '0;
      edges     <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: if (req_valid) begin
          we    <= req_we;
          tx    <= req_we ? wload : rload;
          CS_N  <= 1'b0;
          COPI  <= {3'b000, req_we};
          cnt   <= '0;
          edges <= '0;
          state <= SETUP;
        end
        SETUP: if (tick) begin
          cnt   <= '0;
          SCK   <= 1'b1;
          edges <= edges + 1'b1;
          state <= SHIFT;
        end else cnt <= cnt + 1'b1;
        SHIFT: if (tick) begin
          cnt <= '0;
          if (SCK) begin
            SCK  <= 1'b0;
            COPI <= tx[TXW-1 -: 4];
            tx   <= {tx[TXW-5:0], 4'h0};
            if (last) state <= HOLD;
          end else begin
            SCK   <= 1'b1;
            edges <= edges + 1'b1;
            if (!we && edges >= EW'(RSKIP)) rx <= {rx[RF_WIDTH-5:0], CIPO};
          end
        end else cnt <= cnt + 1'b1;
        HOLD: if (tick) begin
          cnt       <= '0;
          CS_N      <= 1'b1;
          COPI      <= 4'h0;
          rsp_valid <= 1'b1;
          if (!we) rsp_rdata <= rx;
          state     <= GAP;
        end else cnt <= cnt + 1'b1;
        GAP: if (tick) begin
          cnt   <= '0;
          state <= IDLE;
        end else cnt <= cnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_controller.sv
// tb_spi_controller: directed checks of two spi_controller configurations against a quad-SPI peripheral model.
module tb_spi_controller;
  logic clk = 0;
  always #5 clk = ~clk;

  int total = 0, bad = 0;

  logic rst_a, a_valid, a_ready, a_we, a_rsp, a_cs, a_sck;
  logic [7:0] a_addr;
  logic [31:0] a_wdata, a_rdata;
  logic [3:0] a_wmask, a_copi, a_cipo = 4'h0;

  logic rst_b, b_valid, b_ready, b_we, b_rsp, b_cs, b_sck;
  logic [7:0] b_addr;
  logic [31:0] b_wdata, b_rdata;
  logic [3:0] b_wmask, b_copi, b_cipo = 4'h0;

  spi_controller u_a (
    .clk(clk), .rst(rst_a), .req_valid(a_valid), .req_ready(a_ready), .req_we(a_we),
    .req_addr(a_addr), .req_wdata(a_wdata), .req_wmask(a_wmask), .rsp_valid(a_rsp),
    .rsp_rdata(a_rdata), .CS_N(a_cs), .SCK(a_sck), .COPI(a_copi), .CIPO(a_cipo)
  );

  spi_controller #(.CLK_DIV(1), .DUMMY(0)) u_b (
    .clk(clk), .rst(rst_b), .req_valid(b_valid), .req_ready(b_ready), .req_we(b_we),
    .req_addr(b_addr), .req_wdata(b_wdata), .req_wmask(b_wmask), .rsp_valid(b_rsp),
    .rsp_rdata(b_rdata), .CS_N(b_cs), .SCK(b_sck), .COPI(b_copi), .CIPO(b_cipo)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  int a_rises = 0, a_nrsp = 0, a_frames = 0, a_gapc = 0, a_gap = 0;
  logic [63:0] a_word = '0;
  logic [31:0] a_pdata = '0, a_rd_pulse = '0;
  logic a_sck_q = 0, a_cs_q = 1;

  // Peripheral A: 2 dummy cycles, so data nibble d goes out after the fall following rise 5+d.
  always @(negedge clk) begin
    int d;
    if (!a_cs && a_cs_q) begin a_rises = 0; a_word = '0; a_frames++; a_gap = a_gapc; a_gapc = 0; end
    if (a_cs && !a_ready && !rst_a) a_gapc++;
    if (a_sck && !a_sck_q) begin a_word = {a_word[59:0], a_copi}; a_rises++; end
    if (!a_sck && a_sck_q) begin
      d = a_rises - 5;
      a_cipo = (d >= 0 && d < 8) ? a_pdata[31 - 4 * d -: 4] : 4'h0;
    end
    if (a_rsp) begin a_nrsp++; a_rd_pulse = a_rdata; end
    a_sck_q = a_sck;
    a_cs_q = a_cs;
  end

  int b_rises = 0, b_nrsp = 0, b_hirun = 0, b_himax = 0, b_lowcs = 0;
  logic [63:0] b_word = '0;
  logic [31:0] b_pdata = '0;
  logic b_sck_q = 0, b_cs_q = 1;

  always @(negedge clk) begin
    int d;
    if (!b_cs && b_cs_q) begin b_rises = 0; b_word = '0; b_himax = 0; b_lowcs = 0; end
    if (!b_cs) b_lowcs++;
    b_hirun = b_sck ? b_hirun + 1 : 0;
    if (b_hirun > b_himax) b_himax = b_hirun;
    if (b_sck && !b_sck_q) begin b_word = {b_word[59:0], b_copi}; b_rises++; end
    if (!b_sck && b_sck_q) begin
      d = b_rises - 3;
      b_cipo = (d >= 0 && d < 8) ? b_pdata[31 - 4 * d -: 4] : 4'h0;
    end
    if (b_rsp) b_nrsp++;
    b_sck_q = b_sck;
    b_cs_q = b_cs;
  end

  task automatic req_a(input logic we, input logic [7:0] addr, input logic [31:0] wd, input logic [3:0] wm);
    int k = 0;
    @(negedge clk);
    while (!a_ready && k < 500) begin @(negedge clk); k++; end
    check("a_accept_timeout", k < 500, 1);
    a_we = we; a_addr = addr; a_wdata = wd; a_wmask = wm; a_valid = 1;
    @(posedge clk);
    #1 a_valid = 0;
  endtask

  task automatic wait_a;
    int k = 0;
    while (!a_ready && k < 2000) begin @(negedge clk); k++; end
    check("a_done_timeout", k < 2000, 1);
  endtask

  task automatic req_b(input logic we, input logic [7:0] addr, input logic [31:0] wd, input logic [3:0] wm);
    int k = 0;
    @(negedge clk);
    while (!b_ready && k < 500) begin @(negedge clk); k++; end
    check("b_accept_timeout", k < 500, 1);
    b_we = we; b_addr = addr; b_wdata = wd; b_wmask = wm; b_valid = 1;
    @(posedge clk);
    #1 b_valid = 0;
  endtask

  task automatic wait_b;
    int k = 0;
    while (!b_ready && k < 2000) begin @(negedge clk); k++; end
    check("b_done_timeout", k < 2000, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, f0, k;
    a_valid = 0; a_we = 0; a_addr = '0; a_wdata = '0; a_wmask = '0;
    b_valid = 0; b_we = 0; b_addr = '0; b_wdata = '0; b_wmask = '0;
    rst_a = 1; rst_b = 1;
    repeat (3) @(negedge clk);
    check("rst_ready", a_ready, 0);
    check("rst_cs_n", a_cs, 1);
    check("rst_sck", a_sck, 0);
    check("rst_copi", a_copi, 0);
    check("rst_rsp_valid", a_rsp, 0);
    check("rst_rdata", a_rdata, 0);
    rst_a = 0; rst_b = 0;
    #1 check("ready_after_rst", a_ready, 1);

    a_pdata = 32'h12345678; n0 = a_nrsp;
    req_a(0, 8'h05, 32'h0, 4'h0);
    wait_a;
    check("rd_rises", a_rises, 13);
    check("rd_copi", a_word, 64'h0050000000000);
    check("rd_rsp_count", a_nrsp - n0, 1);
    check("rd_pulse_data", a_rd_pulse, 32'h12345678);
    check("rd_rdata", a_rdata, 32'h12345678);

    n0 = a_nrsp; f0 = a_frames;
    req_a(1, 8'h1B, 32'hDEADBEEF, 4'hF);
    repeat (6) @(negedge clk);
    a_valid = 1; a_we = 0; a_addr = 8'hFF;
    @(negedge clk);
    a_valid = 0;
    wait_a;
    repeat (10) @(negedge clk);
    check("wr_rises", a_rises, 12);
    check("wr_copi", a_word, 64'h11BFDEADBEEF);
    check("wr_rsp_count", a_nrsp - n0, 1);
    check("wr_frames", a_frames - f0, 1);
    check("wr_rdata_kept", a_rdata, 32'h12345678);
    check("busy_cs_idle", a_cs, 1);

    a_pdata = 32'h0F1E2D3C; n0 = a_nrsp; f0 = a_frames;
    @(negedge clk);
    a_we = 1; a_addr = 8'h3C; a_wdata = 32'h01234567; a_wmask = 4'h5; a_valid = 1;
    @(posedge clk);
    #1 a_we = 0; a_addr = 8'h2A;
    k = 0;
    @(negedge clk);
    while (!a_ready && k < 2000) begin @(negedge clk); k++; end
    check("b2b_ready_timeout", k < 2000, 1);
    @(posedge clk);
    #1 a_valid = 0;
    wait_a;
    check("b2b_gap", a_gap, 2);
    check("b2b_frames", a_frames - f0, 2);
    check("b2b_rsp_count", a_nrsp - n0, 2);
    check("b2b_rd_copi", a_word, 64'h02A0000000000);
    check("b2b_rdata", a_rdata, 32'h0F1E2D3C);

    a_pdata = 32'hA5A5A5A5; n0 = a_nrsp;
    req_a(0, 8'h77, 32'h0, 4'h0);
    k = 0;
    while (a_rises < 5 && k < 500) begin @(negedge clk); k++; end
    check("abort_edge_timeout", k < 500, 1);
    rst_a = 1;
    #1;
    check("abort_cs_n", a_cs, 1);
    check("abort_sck", a_sck, 0);
    check("abort_copi", a_copi, 0);
    check("abort_ready", a_ready, 0);
    repeat (3) @(negedge clk);
    check("abort_rdata", a_rdata, 0);
    check("abort_no_rsp", a_nrsp - n0, 0);
    rst_a = 0;
    #1 check("abort_ready_after", a_ready, 1);
    a_pdata = 32'h89ABCDEF; n0 = a_nrsp;
    req_a(0, 8'h05, 32'h0, 4'h0);
    wait_a;
    check("post_abort_rises", a_rises, 13);
    check("post_abort_rsp", a_nrsp - n0, 1);
    check("post_abort_rdata", a_rdata, 32'h89ABCDEF);

    b_pdata = 32'hCAFEF00D; n0 = b_nrsp;
    req_b(0, 8'hA7, 32'h0, 4'h0);
    wait_b;
    check("div1_rises", b_rises, 11);
    check("div1_copi", b_word, 64'h0A700000000);
    check("div1_sck_high_run", b_himax, 1);
    check("div1_cs_low_cycles", b_lowcs, 23);
    check("div1_rsp_count", b_nrsp - n0, 1);
    check("div1_rdata", b_rdata, 32'hCAFEF00D);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
